// File: rtl/vxv_stream_pkg.sv
// rtl/vxv_stream_pkg.sv - shared state type and sizing helpers for the vector chunk streamer
package vxv_stream_pkg;

  // Streamer sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } vxv_state_t;

  // Number of whole chunks needed to cover a vector (no trailing all-zero chunk)
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Bits needed to index n items, never less than one bit
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/vec_chunk_select.sv
// rtl/vec_chunk_select.sv - combinational zero-padded chunk selector for one packed vector
module vec_chunk_select
  import vxv_stream_pkg::*;
#(
  parameter int NOE           = 10,
  parameter int NO_OF_UNITS   = 8,
  parameter int ELEMENT_WIDTH = 32,
  parameter int IDX_W         = 1
) (
  input  logic [ELEMENT_WIDTH*NOE-1:0]         vec,
  input  logic [IDX_W-1:0]                     idx,
  output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] chunk
);

  localparam int NUM_CHUNKS = ceil_div(NOE, NO_OF_UNITS);
  localparam int CHUNK_W    = ELEMENT_WIDTH * NO_OF_UNITS;
  localparam int TOTAL_W    = NUM_CHUNKS * CHUNK_W;

  // The vector zero-extended to a whole number of chunks, so padding lanes fall out as zeros
  logic [TOTAL_W-1:0] padded;

  assign padded = TOTAL_W'(vec);

  // Pick the chunk whose number matches idx; out-of-range indices give all zeros
  always_comb begin
    chunk = '0;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (idx == IDX_W'(k)) begin
        chunk = padded[k*CHUNK_W +: CHUNK_W];
      end
    end
  end

endmodule

// File: rtl/vector_chunk_streamer.sv
// rtl/vector_chunk_streamer.sv - latches two vectors and streams them as chunk pairs; optional VEC_STREAM_LANE_MASK_EN adds a lane mask
module vector_chunk_streamer
  import vxv_stream_pkg::*;
#(
  parameter int NOE           = 10,
  parameter int ELEMENT_WIDTH = 32,
  parameter int NO_OF_UNITS   = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [ELEMENT_WIDTH*NOE-1:0]         vector1,
  input  logic [ELEMENT_WIDTH*NOE-1:0]         vector2,
  output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] first_row_plus_additional,
  output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] second_row_plus_additional,
  output logic                                 chunk_valid,
  input  logic                                 chunk_ready,
  output logic                                 chunk_last,
  output logic                                 busy,
  output logic                                 done
`ifdef VEC_STREAM_LANE_MASK_EN
  ,
  output logic [NO_OF_UNITS-1:0]               chunk_lane_mask
`endif
);

  localparam int NUM_CHUNKS = ceil_div(NOE, NO_OF_UNITS);
  localparam int IDX_W      = clog2_min1(NUM_CHUNKS);
  localparam int VEC_W      = ELEMENT_WIDTH * NOE;
  localparam int CHUNK_W    = ELEMENT_WIDTH * NO_OF_UNITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  vxv_state_t       state;
  vxv_state_t       state_next;
  logic [VEC_W-1:0] v1_q;
  logic [VEC_W-1:0] v2_q;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_inc;
  logic [IDX_W-1:0] sel_idx;
  logic [VEC_W-1:0] sel_v1;
  logic [VEC_W-1:0] sel_v2;
  logic [CHUNK_W-1:0] sel_chunk1;
  logic [CHUNK_W-1:0] sel_chunk2;
  logic             xfer;
  logic             at_last;

  assign xfer    = chunk_valid && chunk_ready;
  assign at_last = (idx == LAST_IDX);
  assign idx_inc = idx + IDX_W'(1);

  // In IDLE the selector looks straight at the inputs so chunk 0 lands one cycle after start;
  // while streaming it prepares the chunk that follows the one currently presented.
  assign sel_v1  = (state == IDLE) ? vector1 : v1_q;
  assign sel_v2  = (state == IDLE) ? vector2 : v2_q;
  assign sel_idx = (state == IDLE) ? '0 : idx_inc;

  vec_chunk_select #(
    .NOE          (NOE),
    .NO_OF_UNITS  (NO_OF_UNITS),
    .ELEMENT_WIDTH(ELEMENT_WIDTH),
    .IDX_W        (IDX_W)
  ) u_sel1 (
    .vec  (sel_v1),
    .idx  (sel_idx),
    .chunk(sel_chunk1)
  );

  vec_chunk_select #(
    .NOE          (NOE),
    .NO_OF_UNITS  (NO_OF_UNITS),
    .ELEMENT_WIDTH(ELEMENT_WIDTH),
    .IDX_W        (IDX_W)
  ) u_sel2 (
    .vec  (sel_v2),
    .idx  (sel_idx),
    .chunk(sel_chunk2)
  );

  assign chunk_last = chunk_valid && at_last;
  assign busy       = (state != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: start only matters in IDLE, the last accepted chunk ends the stream
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = STREAM;
      STREAM:  if (xfer && at_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Vector latches, chunk index and registered chunk outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q                       <= '0;
      v2_q                       <= '0;
      idx                        <= '0;
      first_row_plus_additional  <= '0;
      second_row_plus_additional <= '0;
      chunk_valid                <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            v1_q                       <= vector1;
            v2_q                       <= vector2;
            idx                        <= '0;
            first_row_plus_additional  <= sel_chunk1;
            second_row_plus_additional <= sel_chunk2;
            chunk_valid                <= 1'b1;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (at_last) begin
              idx                        <= '0;
              first_row_plus_additional  <= '0;
              second_row_plus_additional <= '0;
              chunk_valid                <= 1'b0;
            end else begin
              idx                        <= idx_inc;
              first_row_plus_additional  <= sel_chunk1;
              second_row_plus_additional <= sel_chunk2;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Done pulses on the cycle after the DONE state, so a new start can be taken alongside it
  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0;
    end else begin
      done <= (state == DONE);
    end
  end

`ifdef VEC_STREAM_LANE_MASK_EN
  logic [NO_OF_UNITS-1:0] mask_next;

  // Lanes of the upcoming chunk that hold a real element rather than padding
  always_comb begin
    mask_next = '0;
    for (int j = 0; j < NO_OF_UNITS; j++) begin
      if ((int'(sel_idx) * NO_OF_UNITS + j) < NOE) begin
        mask_next[j] = 1'b1;
      end
    end
  end

  // Lane mask register, loaded and cleared in step with the chunk outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      chunk_lane_mask <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        chunk_lane_mask <= mask_next;
      end
    end else if (state == STREAM && xfer) begin
      chunk_lane_mask <= at_last ? '0 : mask_next;
    end
  end
`endif

endmodule

// File: tb/tb_vector_chunk_streamer.sv
// tb/tb_vector_chunk_streamer.sv - scoreboard bench over three vector lengths (10, 16, 3 elements)
module tb_vector_chunk_streamer;

  typedef struct {
    logic [255:0] r1;
    logic [255:0] r2;
    logic         last;
    logic [7:0]   mask;
  } exp_t;

  logic clk;
  int   total;
  int   bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int N   = (g == 0) ? 10 : (g == 1) ? 16 : 3;
    localparam int NCH = (N + 7) / 8;

    logic             rst;
    logic             start;
    logic             rdy;
    logic [32*N-1:0]  v1;
    logic [32*N-1:0]  v2;
    logic [255:0]     r1;
    logic [255:0]     r2;
    logic             cv;
    logic             cl;
    logic             bsy;
    logic             dn;
`ifdef VEC_STREAM_LANE_MASK_EN
    logic [7:0]       mk;
`endif
    exp_t             q[$];
    int               done_q[$];
    int               cyc;
    bit               exp_v_next;
    bit               fin;

    vector_chunk_streamer #(
      .NOE          (N),
      .ELEMENT_WIDTH(32),
      .NO_OF_UNITS  (8)
    ) dut (
      .clk                       (clk),
      .reset                     (rst),
      .start                     (start),
      .vector1                   (v1),
      .vector2                   (v2),
      .first_row_plus_additional (r1),
      .second_row_plus_additional(r2),
      .chunk_valid               (cv),
      .chunk_ready               (rdy),
      .chunk_last                (cl),
      .busy                      (bsy),
      .done                      (dn)
`ifdef VEC_STREAM_LANE_MASK_EN
      ,
      .chunk_lane_mask           (mk)
`endif
    );

    // Reference: element e of vector lands in chunk e/8 lane e%8; unused lanes are zero
    task automatic push_exp();
      exp_t e;
      int   el;
      for (int k = 0; k < NCH; k++) begin
        e.r1 = '0;
        e.r2 = '0;
        e.mask = '0;
        for (int j = 0; j < 8; j++) begin
          el = k * 8 + j;
          if (el < N) begin
            e.r1[j*32 +: 32] = v1[el*32 +: 32];
            e.r2[j*32 +: 32] = v2[el*32 +: 32];
            e.mask[j] = 1'b1;
          end
        end
        e.last = (k == NCH - 1);
        q.push_back(e);
      end
    endtask

    task automatic rand_vecs();
      for (int i = 0; i < N; i++) begin
        v1[i*32 +: 32] = $urandom;
        v2[i*32 +: 32] = $urandom;
      end
    endtask

    // mode 0: ready held high, 1: ready low for three cycles first, 2: random ready
    task automatic run_stream(input int mode, input bit inj);
      bit got;
      got = 0;
      push_exp();
      start = 1'b1;
      rdy = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      chk($sformatf("n%0d_latency", N), 256'(cv), 256'(1));
      for (int c = 0; c < 300; c++) begin
        if (mode == 0) rdy = 1'b1;
        else if (mode == 1) rdy = (c >= 3);
        else rdy = ($urandom_range(0, 2) != 0);
        if (inj && c == 0) begin
          start = 1'b1;
          rand_vecs();
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
        if (dn) begin
          got = 1;
          break;
        end
      end
      start = 1'b0;
      if (!got) chk($sformatf("n%0d_done_timeout", N), 256'(0), 256'(1));
    endtask

    // Driver
    initial begin
      fin = 0;
      rst = 1'b1;
      start = 1'b0;
      rdy = 1'b0;
      v1 = '0;
      v2 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("n%0d_reset_busy", N), 256'(bsy), 256'(0));
      chk($sformatf("n%0d_reset_valid", N), 256'(cv), 256'(0));
      chk($sformatf("n%0d_reset_done", N), 256'(dn), 256'(0));
      chk($sformatf("n%0d_reset_row1", N), r1, 256'(0));
      rst = 1'b0;

      for (int i = 0; i < N; i++) begin
        v1[i*32 +: 32] = 32'(i + 1);
        v2[i*32 +: 32] = 32'(i + 101);
      end
      run_stream(0, 0);
      rand_vecs();
      run_stream(1, 0);
      rand_vecs();
      run_stream(0, 1);

      // abandon a stream with reset while a chunk is presented
      rand_vecs();
      push_exp();
      start = 1'b1;
      rdy = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      rdy = (NCH > 1);
      @(posedge clk); #1;
      rdy = 1'b0;
      rst = 1'b1;
      q.delete();
      done_q.delete();
      @(posedge clk); #1;
      chk($sformatf("n%0d_midrst_valid", N), 256'(cv), 256'(0));
      chk($sformatf("n%0d_midrst_busy", N), 256'(bsy), 256'(0));
      chk($sformatf("n%0d_midrst_last", N), 256'(cl), 256'(0));
      chk($sformatf("n%0d_midrst_row2", N), r2, 256'(0));
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      for (int i = 0; i < N; i++) begin
        v1[i*32 +: 32] = 32'(i + 1);
        v2[i*32 +: 32] = 32'(i + 101);
      end
      run_stream(0, 0);
      repeat (25) begin
        rand_vecs();
        run_stream(2, ($urandom_range(0, 1) == 1));
      end
      repeat (5) @(posedge clk);
      #1;
      chk($sformatf("n%0d_chunks_left", N), 256'(q.size()), 256'(0));
      chk($sformatf("n%0d_dones_left", N), 256'(done_q.size()), 256'(0));
      fin = 1;
    end

    // Monitor: compare every presented chunk against the scoreboard head
    always @(negedge clk) begin
      bit exp_d;
      cyc++;
      if (!rst) begin
        if (exp_v_next) chk($sformatf("n%0d_no_bubble", N), 256'(cv), 256'(1));
        exp_v_next = 0;
        if (cv) begin
          if (q.size() == 0) begin
            chk($sformatf("n%0d_unexpected_chunk", N), 256'(cv), 256'(0));
          end else begin
            chk($sformatf("n%0d_row1", N), r1, q[0].r1);
            chk($sformatf("n%0d_row2", N), r2, q[0].r2);
            chk($sformatf("n%0d_last", N), 256'(cl), 256'(q[0].last));
`ifdef VEC_STREAM_LANE_MASK_EN
            chk($sformatf("n%0d_mask", N), 256'(mk), 256'(q[0].mask));
`endif
            if (rdy) begin
              if (q[0].last) done_q.push_back(cyc + 2);
              else exp_v_next = 1;
              q.pop_front();
            end
          end
        end else begin
          chk($sformatf("n%0d_idle_row1", N), r1, 256'(0));
          chk($sformatf("n%0d_idle_row2", N), r2, 256'(0));
          chk($sformatf("n%0d_idle_last", N), 256'(cl), 256'(0));
`ifdef VEC_STREAM_LANE_MASK_EN
          chk($sformatf("n%0d_idle_mask", N), 256'(mk), 256'(0));
`endif
        end
        exp_d = (done_q.size() > 0) && (done_q[0] == cyc);
        chk($sformatf("n%0d_done", N), 256'(dn), 256'(exp_d));
        if (exp_d) void'(done_q.pop_front());
      end else begin
        exp_v_next = 0;
      end
    end
  end

  initial begin
    total = 0;
    bad = 0;
    wait (u[0].fin && u[1].fin && u[2].fin);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
